// File: rtl/data_bus_arbiter.sv
// N-master arbiter for the shared data-memory port: optional absolute priority for master 0,
// round-robin among the rest. Defining DBUS_ARB_TIMEOUT_EN adds a busy-timeout abort (m_err).
module data_bus_arbiter #(
    parameter int unsigned MASTERS = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PRIO0   = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*MASTERS-1:0]       m_rw,
    input  logic [2*MASTERS-1:0]       m_size,
    input  logic [ADDR_W*MASTERS-1:0]  m_addr,
    input  logic [DATA_W*MASTERS-1:0]  m_wdata,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [MASTERS-1:0]         m_grant,
    output logic [MASTERS-1:0]         m_cplt,
    output logic [MASTERS-1:0]         m_err,
    output logic [$clog2(MASTERS)-1:0] grant_id,
    output logic [1:0]                 data_rw,
    output logic [1:0]                 data_size,
    output logic [ADDR_W-1:0]          data_address,
    output logic [DATA_W-1:0]          data_wdata,
    input  logic [DATA_W-1:0]          data_rdata,
    input  logic                       data_rw_cplt
);

    localparam int unsigned ID_W = $clog2(MASTERS);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_q;
    logic [MASTERS-1:0] grant_q;
    logic [ID_W-1:0]    gid_q;
    logic [ID_W-1:0]    ptr_q;
    logic [MASTERS-1:0] req;
    logic [ID_W-1:0]    win_d;
    logic               win_prio_d;
    logic               busy;
    logic               g_req;

    // Codes 2 (read) and 3 (write) are requests, i.e. the upper rw bit.
    for (genvar i = 0; i < MASTERS; i++) begin : g_req_bit
        assign req[i] = m_rw[2*i+1];
    end

    assign busy  = (state_q == BUSY);
    assign g_req = req[gid_q];

    // Winner: master 0 outright when prioritised, otherwise first requester after the pointer.
    always_comb begin
        int unsigned idx;
        logic        found;
        win_d      = '0;
        win_prio_d = 1'b0;
        found      = 1'b0;
        idx        = 0;
        if (PRIO0 != 0 && req[0]) begin
            win_prio_d = 1'b1;
            found      = 1'b1;
        end
        for (int unsigned k = 1; k <= MASTERS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= MASTERS) begin
                idx = idx - MASTERS;
            end
            if (!found && req[ID_W'(idx)] && !(PRIO0 != 0 && idx == 0)) begin
                found = 1'b1;
                win_d = ID_W'(idx);
            end
        end
    end

    // Slave port mirrors the granted master while busy, idle-zero otherwise.
    always_comb begin
        data_rw      = '0;
        data_size    = '0;
        data_address = '0;
        data_wdata   = '0;
        if (busy) begin
            for (int unsigned i = 0; i < MASTERS; i++) begin
                if (gid_q == ID_W'(i)) begin
                    data_rw      = m_rw[2*i +: 2];
                    data_size    = m_size[2*i +: 2];
                    data_address = m_addr[ADDR_W*i +: ADDR_W];
                    data_wdata   = m_wdata[DATA_W*i +: DATA_W];
                end
            end
        end
    end

    assign m_rdata  = data_rdata;
    assign m_cplt   = (data_rw_cplt && busy) ? grant_q : '0;
    assign m_grant  = grant_q;
    assign grant_id = gid_q;

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]   cnt_q;
    logic [MASTERS-1:0] err_q;

    assign m_err = err_q;
`else
    assign m_err = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= ID_W'(MASTERS - 1);
`ifdef DBUS_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
`ifdef DBUS_ARB_TIMEOUT_EN
            err_q <= '0;
`endif
            if (state_q == IDLE) begin
                if (|req) begin
                    state_q <= BUSY;
                    grant_q <= MASTERS'(1) << win_d;
                    gid_q   <= win_d;
                    if (!win_prio_d) begin
                        ptr_q <= win_d;
                    end
`ifdef DBUS_ARB_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                end
            end else begin
                // Completion wins over a simultaneous request drop or timeout.
                if (data_rw_cplt || !g_req) begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
`ifdef DBUS_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    err_q   <= grant_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: two instances (PRIO0=1 and PRIO0=0) on shared stimulus,
// checked every cycle against a transaction-level model plus hand-computed literals.
module tb_data_bus_arbiter;

    localparam int M  = 4;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rw [M];
    logic [1:0]  sz [M];
    logic [31:0] ad [M];
    logic [31:0] wd [M];
    logic [31:0] rdata = 32'h0;
    logic        cplt  = 1'b0;

    logic [2*M-1:0]  rw_v, sz_v;
    logic [32*M-1:0] ad_v, wd_v;

    always_comb begin
        for (int i = 0; i < M; i++) begin
            rw_v[2*i +: 2]  = rw[i];
            sz_v[2*i +: 2]  = sz[i];
            ad_v[32*i +: 32] = ad[i];
            wd_v[32*i +: 32] = wd[i];
        end
    end

    // Index 0: PRIO0=1, index 1: PRIO0=0.
    logic [1:0][31:0] o_rdata, o_addr, o_wdata;
    logic [1:0][3:0]  o_grant, o_cplt, o_err;
    logic [1:0][1:0]  o_gid, o_rw, o_size;

    data_bus_arbiter #(.MASTERS(M), .ADDR_W(32), .DATA_W(32), .PRIO0(1), .TIMEOUT(TO)) u_prio (
        .clk(clk), .rst(rst), .m_rw(rw_v), .m_size(sz_v), .m_addr(ad_v), .m_wdata(wd_v),
        .m_rdata(o_rdata[0]), .m_grant(o_grant[0]), .m_cplt(o_cplt[0]), .m_err(o_err[0]),
        .grant_id(o_gid[0]), .data_rw(o_rw[0]), .data_size(o_size[0]), .data_address(o_addr[0]),
        .data_wdata(o_wdata[0]), .data_rdata(rdata), .data_rw_cplt(cplt));

    data_bus_arbiter #(.MASTERS(M), .ADDR_W(32), .DATA_W(32), .PRIO0(0), .TIMEOUT(TO)) u_rr (
        .clk(clk), .rst(rst), .m_rw(rw_v), .m_size(sz_v), .m_addr(ad_v), .m_wdata(wd_v),
        .m_rdata(o_rdata[1]), .m_grant(o_grant[1]), .m_cplt(o_cplt[1]), .m_err(o_err[1]),
        .grant_id(o_gid[1]), .data_rw(o_rw[1]), .data_size(o_size[1]), .data_address(o_addr[1]),
        .data_wdata(o_wdata[1]), .data_rdata(rdata), .data_rw_cplt(cplt));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: who owns the bus, rotation pointer, busy-cycle count, pending error pulse.
    bit         mbusy [2] = '{0, 0};
    int         mgid  [2] = '{0, 0};
    int         mptr  [2] = '{M-1, M-1};
    int         mcnt  [2] = '{0, 0};
    logic [3:0] merr  [2] = '{4'h0, 4'h0};

    always @(posedge clk or posedge rst) begin
        int w;
        bit pr, byprio;
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                mbusy[n] <= 1'b0;
                mgid[n]  <= 0;
                mptr[n]  <= M - 1;
                mcnt[n]  <= 0;
                merr[n]  <= 4'h0;
            end else begin
                merr[n] <= 4'h0;
                pr      = (n == 0);
                byprio  = 1'b0;
                if (!mbusy[n]) begin
                    w = -1;
                    if (pr && rw[0] >= 2) begin
                        w      = 0;
                        byprio = 1'b1;
                    end else begin
                        for (int k = 1; k <= M; k++) begin
                            int c;
                            c = (mptr[n] + k) % M;
                            if (w < 0 && rw[c] >= 2 && !(pr && c == 0)) w = c;
                        end
                    end
                    if (w >= 0) begin
                        mbusy[n] <= 1'b1;
                        mgid[n]  <= w;
                        mcnt[n]  <= 0;
                        if (!byprio) mptr[n] <= w;
                    end
                end else if (cplt) begin
                    mbusy[n] <= 1'b0;
                end else if (rw[mgid[n]] < 2) begin
                    mbusy[n] <= 1'b0;
                end else begin
`ifdef DBUS_ARB_TIMEOUT_EN
                    if (mcnt[n] + 1 == TO) begin
                        mbusy[n] <= 1'b0;
                        merr[n]  <= 4'(1 << mgid[n]);
                    end else begin
                        mcnt[n] <= mcnt[n] + 1;
                    end
`endif
                end
            end
        end
    end

    bit armed = 1'b0;

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] eg, ec;
        int g;
        if (armed) begin
            for (int n = 0; n < 2; n++) begin
                g  = mgid[n];
                eg = mbusy[n] ? 4'(1 << g) : 4'h0;
                ec = (mbusy[n] && cplt) ? eg : 4'h0;
                chk($sformatf("m_grant[%0d]", n), 64'(o_grant[n]), 64'(eg));
                chk($sformatf("grant_id[%0d]", n), 64'(o_gid[n]), 64'(g));
                chk($sformatf("m_cplt[%0d]", n), 64'(o_cplt[n]), 64'(ec));
                chk($sformatf("m_err[%0d]", n), 64'(o_err[n]), 64'(merr[n]));
                chk($sformatf("m_rdata[%0d]", n), 64'(o_rdata[n]), 64'(rdata));
                chk($sformatf("data_rw[%0d]", n), 64'(o_rw[n]), mbusy[n] ? 64'(rw[g]) : 64'h0);
                chk($sformatf("data_size[%0d]", n), 64'(o_size[n]), mbusy[n] ? 64'(sz[g]) : 64'h0);
                chk($sformatf("data_addr[%0d]", n), 64'(o_addr[n]), mbusy[n] ? 64'(ad[g]) : 64'h0);
                chk($sformatf("data_wdata[%0d]", n), 64'(o_wdata[n]), mbusy[n] ? 64'(wd[g]) : 64'h0);
            end
        end
    end

    initial begin
        int q[$];
        int exp_rr [6];
        exp_rr = '{3, 1, 2, 3, 1, 2};
        for (int i = 0; i < M; i++) begin
            rw[i] = 2'd0; sz[i] = 2'd0; ad[i] = 32'h0; wd[i] = 32'h0;
        end
        #2 rst = 1'b1;
        armed = 1'b1;
        #1;
        chk("reset grant", 64'(o_grant[0]), 64'h0);
        chk("reset grant_id", 64'(o_gid[0]), 64'h0);
        chk("reset data_rw", 64'(o_rw[0]), 64'h0);
        tick();
        rst = 1'b0;

        // Single master read
        rw[2] = 2'd2; sz[2] = 2'd3; ad[2] = 32'h1000; rdata = 32'hDEADBEEF;
        tick();
        chk("single grant", 64'(o_grant[0]), 64'h4);
        chk("single addr", 64'(o_addr[0]), 64'h1000);
        chk("single rw", 64'(o_rw[0]), 64'h2);
        tick();
        tick();
        cplt = 1'b1;
        #1;
        chk("single cplt", 64'(o_cplt[0]), 64'h4);
        chk("single rdata", 64'(o_rdata[0]), 64'hDEADBEEF);
        tick();
        chk("single idle grant", 64'(o_grant[0]), 64'h0);
        chk("single gid holds", 64'(o_gid[0]), 64'h2);
        cplt = 1'b0; rw[2] = 2'd0;
        tick();
        chk("single stays idle", 64'(o_grant[0]), 64'h0);

        // Round-robin among 1..3 with a one-cycle slave
        rw[1] = 2'd2; rw[2] = 2'd2; rw[3] = 2'd2; cplt = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_grant[0] != 4'h0) q.push_back(int'(o_gid[0]));
        end
        rw[1] = 2'd0; rw[2] = 2'd0; rw[3] = 2'd0; cplt = 1'b0;
        chk("rr grant count", 64'(q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr order %0d", i), (q.size() > i) ? 64'(q[i]) : 64'hFF, 64'(exp_rr[i]));
        end
        tick();

        // Master 0 arrives while master 3 is busy
        rw[3] = 2'd2;
        tick();
        chk("prio m3 grant", 64'(o_grant[0]), 64'h8);
        rw[0] = 2'd2; rw[1] = 2'd2; rw[2] = 2'd2;
        tick();
        chk("prio m3 holds", 64'(o_gid[0]), 64'h3);
        cplt = 1'b1;
        #1;
        chk("prio m3 cplt", 64'(o_cplt[0]), 64'h8);
        tick();
        chk("prio gap", 64'(o_grant[0]), 64'h0);
        cplt = 1'b0; rw[3] = 2'd0;
        tick();
        chk("prio m0 wins", 64'(o_grant[0]), 64'h1);
        rw[0] = 2'd0; cplt = 1'b1;
        #1;
        chk("drop+cplt is cplt", 64'(o_cplt[0]), 64'h1);
        tick();
        rw[1] = 2'd0; rw[2] = 2'd0; cplt = 1'b0;
        tick();

        // Write path, then request drop; arbitration differs between instances
        rw[1] = 2'd3; sz[1] = 2'd3; wd[1] = 32'hCAFEF00D; ad[1] = 32'h2004;
        tick();
        chk("wr grant", 64'(o_grant[0]), 64'h2);
        chk("wr rw", 64'(o_rw[0]), 64'h3);
        chk("wr size", 64'(o_size[0]), 64'h3);
        chk("wr wdata", 64'(o_wdata[0]), 64'hCAFEF00D);
        chk("wr addr", 64'(o_addr[0]), 64'h2004);
        rw[0] = 2'd2; rw[2] = 2'd2; rw[3] = 2'd2;
        tick();
        rw[1] = 2'd0;
        #1;
        chk("drop no cplt", 64'(o_cplt[0]), 64'h0);
        tick();
        chk("drop idle", 64'(o_grant[0]), 64'h0);
        chk("drop no err", 64'(o_err[0]), 64'h0);
        tick();
        chk("after drop prio", 64'(o_grant[0]), 64'h1);
        chk("after drop rr", 64'(o_grant[1]), 64'h4);
        rw[0] = 2'd0; rw[2] = 2'd0; rw[3] = 2'd0; cplt = 1'b1;
        tick();
        cplt = 1'b0;
        tick();

        // Slave never completes
        rw[2] = 2'd2;
        tick();
        repeat (10) tick();
`ifdef DBUS_ARB_TIMEOUT_EN
        chk("timeout err", 64'(o_err[0]), 64'h4);
        chk("timeout release", 64'(o_grant[0]), 64'h0);
`else
        chk("no timeout busy", 64'(o_grant[0]), 64'h4);
        chk("no timeout err", 64'(o_err[0]), 64'h0);
`endif
        rw[2] = 2'd0;
        tick();
        tick();

        // Completion on the tenth busy cycle
        rw[2] = 2'd2;
        tick();
        repeat (9) tick();
        cplt = 1'b1;
        #1;
        chk("late cplt", 64'(o_cplt[0]), 64'h4);
        tick();
        chk("late no err", 64'(o_err[0]), 64'h0);
        chk("late idle", 64'(o_grant[0]), 64'h0);
        cplt = 1'b0; rw[2] = 2'd0;
        tick();

        // Async reset mid-transfer
        rw[3] = 2'd2;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst grant", 64'(o_grant[0]), 64'h0);
        chk("arst gid", 64'(o_gid[0]), 64'h0);
        chk("arst data_rw", 64'(o_rw[0]), 64'h0);
        chk("arst addr", 64'(o_addr[0]), 64'h0);
        #1 rst = 1'b0;
        rw[3] = 2'd0; rw[0] = 2'd2; rw[1] = 2'd2;
        tick();
        chk("post-reset rr m0", 64'(o_grant[1]), 64'h1);
        rw[0] = 2'd0; rw[1] = 2'd0; cplt = 1'b1;
        tick();
        cplt = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
